// File: rtl/idli_pkg.sv
// Shared types and constants for the idli decode front end.
package idli_pkg;

  // Nibbles in one instruction word, and in one trailing immediate.
  localparam int unsigned NIBBLES_PER_INSN = 4;

  // Width of the per-phase nibble counter.
  localparam int unsigned SEQ_CNT_W = $clog2(NIBBLES_PER_INSN);

  // Decode sequencer phases.
  typedef enum logic [1:0] {
    Idle = 2'd0,
    Insn = 2'd1,
    Imm  = 2'd2
  } seq_state_t;

  // True on the final nibble of an instruction or immediate phase.
  function automatic logic seq_cnt_last(input logic [SEQ_CNT_W-1:0] cnt);
    return cnt == SEQ_CNT_W'(NIBBLES_PER_INSN - 1);
  endfunction

endpackage

// File: rtl/idli_nib_fifo_m.sv
// Fall-through nibble FIFO. The head entry is visible combinationally and
// clear has priority over push and pop.
module idli_nib_fifo_m #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_gck,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [3:0]               i_data,
  output logic [$clog2(DEPTH):0]   o_occ,
  output logic [3:0]               o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   occ_q;

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge i_gck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else if (i_clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (i_push) wptr_q <= wptr_q + 1'b1;
      if (i_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage; reset so the head reads 0 rather than X out of reset.
  always_ff @(posedge i_gck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (i_push && !i_clr) begin
      // At full with a pop, this slot is the head being read this cycle.
      mem_q[wptr_q] <= i_data;
    end
  end

  assign o_occ  = occ_q;
  assign o_head = mem_q[rptr_q];

endmodule

// File: rtl/idli_dcd_seq_m.sv
// Decode sequencer: buffers the SQI nibble stream and starts an instruction
// only once every nibble it could need is already buffered, because the
// decoder cannot be paused mid-instruction. A flush mid-instruction feeds
// zero filler nibbles so the decoder completes, and kills the resulting op.
module idli_dcd_seq_m
  import idli_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,  // power of two, >= 8
  parameter int unsigned START_THR = 8    // 8 <= START_THR <= DEPTH
) (
  input  logic       i_dcd_gck,
  input  logic       i_dcd_rst_n,
  input  logic [3:0] i_mem_data,
  input  logic       i_mem_vld,
  output logic       o_mem_rdy,
  input  logic       i_flush,
  input  logic       i_exe_stall,
  output logic [3:0] o_dcd_enc,
  output logic       o_dcd_enc_vld,
  input  logic       i_dcd_op_vld,
  input  logic       i_dcd_imm,
  output logic       o_exe_op_vld,
  output logic       o_busy
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_OCC  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] START_OCC = OCC_W'(START_THR);

  logic [OCC_W-1:0]     occ;
  logic [3:0]           head;
  logic                 push;
  logic                 pop;
  logic                 start;

  seq_state_t           state_q;
  logic [SEQ_CNT_W-1:0] cnt_q;
  logic                 kill_q;    // op of the current instruction must not reach execute
  logic                 filler_q;  // drive zeros instead of FIFO data

  idli_nib_fifo_m #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_gck   (i_dcd_gck),
    .i_rst_n (i_dcd_rst_n),
    .i_clr   (i_flush),
    .i_push  (push),
    .i_pop   (pop),
    .i_data  (i_mem_data),
    .o_occ   (occ),
    .o_head  (head)
  );

  // Start and nibble handshakes; the first nibble goes out in the start cycle.
  always_comb begin
    start         = (state_q == Idle) && (occ >= START_OCC) && !i_exe_stall && !i_flush;
    o_dcd_enc_vld = start || (state_q != Idle);
    pop           = o_dcd_enc_vld && !filler_q;
    o_mem_rdy     = (occ != FULL_OCC) || pop;
    push          = i_mem_vld && o_mem_rdy;
    o_dcd_enc     = filler_q ? 4'h0 : head;
    o_busy        = (state_q != Idle);
    o_exe_op_vld  = i_dcd_op_vld && !kill_q && !i_flush;
  end

  // Sequencer FSM. The start cycle is nibble 0, so Insn begins at cnt=1.
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      state_q  <= Idle;
      cnt_q    <= '0;
      kill_q   <= 1'b0;
      filler_q <= 1'b0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (start) begin
            state_q <= Insn;
            cnt_q   <= SEQ_CNT_W'(1);
          end
        end
        Insn: begin
          if (seq_cnt_last(cnt_q)) begin
            cnt_q <= '0;
            if (i_dcd_imm) begin
              // Immediate still runs (possibly on filler) so the decoder finishes.
              state_q <= Imm;
              if (i_flush) begin
                kill_q   <= 1'b1;
                filler_q <= 1'b1;
              end
            end else begin
              state_q  <= Idle;
              kill_q   <= 1'b0;
              filler_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (i_flush) begin
              kill_q   <= 1'b1;
              filler_q <= 1'b1;
            end
          end
        end
        Imm: begin
          if (seq_cnt_last(cnt_q)) begin
            state_q  <= Idle;
            cnt_q    <= '0;
            kill_q   <= 1'b0;
            filler_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (i_flush) begin
              kill_q   <= 1'b1;
              filler_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= Idle;
          cnt_q    <= '0;
          kill_q   <= 1'b0;
          filler_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_dcd_seq_m.sv
// Directed bench for the decode sequencer. Inputs change 1 time unit after
// the rising edge; outputs are checked 1 unit later, well away from the edge.
module tb_idli_dcd_seq_m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mem_data = '0;
  logic       mem_vld = 1'b0;
  logic       mem_rdy;
  logic       flush = 1'b0;
  logic       exe_stall = 1'b0;
  logic [3:0] dcd_enc;
  logic       dcd_enc_vld;
  logic       dcd_op_vld = 1'b0;
  logic       dcd_imm = 1'b0;
  logic       exe_op_vld;
  logic       busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  idli_dcd_seq_m #(
    .DEPTH     (16),
    .START_THR (8)
  ) dut (
    .i_dcd_gck     (clk),
    .i_dcd_rst_n   (rst_n),
    .i_mem_data    (mem_data),
    .i_mem_vld     (mem_vld),
    .o_mem_rdy     (mem_rdy),
    .i_flush       (flush),
    .i_exe_stall   (exe_stall),
    .o_dcd_enc     (dcd_enc),
    .o_dcd_enc_vld (dcd_enc_vld),
    .i_dcd_op_vld  (dcd_op_vld),
    .i_dcd_imm     (dcd_imm),
    .o_exe_op_vld  (exe_op_vld),
    .o_busy        (busy)
  );

  logic [4:0] occ;
  assign occ = dut.u_fifo.o_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [3:0] d);
    mem_vld  = 1'b1;
    mem_data = d;
    cyc();
    mem_vld  = 1'b0;
  endtask

  logic [3:0] nib1 [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hC, 4'h1, 4'h2, 4'h3};
  logic [3:0] wrap_exp [20] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF,
                                4'h9, 4'h8, 4'h7, 4'h6};

  initial begin
    int nvld;
    int nbusy;

    // Reset values
    #2;
    chk("rst_vld", dcd_enc_vld, 0);
    chk("rst_enc", dcd_enc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", mem_rdy, 1);
    chk("rst_exe", exe_op_vld, 0);
    chk("rst_occ", occ, 0);
    cyc();
    rst_n = 1'b1;

    // Threshold: 7 nibbles never start
    for (int i = 0; i < 7; i++) push_n(nib1[i]);
    #1;
    chk("thr7_occ", occ, 7);
    chk("thr7_vld", dcd_enc_vld, 0);
    push_n(nib1[7]);

    // First insn starts as occ reaches 8; refill 4,5,6,7 while it runs
    for (int i = 0; i < 4; i++) begin
      mem_vld    = 1'b1;
      mem_data   = 4'(4 + i);
      dcd_op_vld = (i == 3);
      #1;
      chk("i1_enc", dcd_enc, nib1[i]);
      chk("i1_vld", dcd_enc_vld, 1);
      chk("i1_busy", busy, (i != 0));
      chk("i1_rdy", mem_rdy, 1);
      if (i == 3) chk("i1_exe", exe_op_vld, 1);
      cyc();
    end
    mem_vld    = 1'b0;
    dcd_op_vld = 1'b0;

    // Back-to-back second insn C,1,2,3 with no gap
    for (int i = 0; i < 4; i++) begin
      dcd_op_vld = (i == 3);
      #1;
      chk("i2_enc", dcd_enc, nib1[4 + i]);
      chk("i2_vld", dcd_enc_vld, 1);
      if (i == 3) chk("i2_exe", exe_op_vld, 1);
      cyc();
    end
    dcd_op_vld = 1'b0;
    #1;
    chk("i2_idle_vld", dcd_enc_vld, 0);
    chk("i2_idle_busy", busy, 0);
    chk("i2_occ", occ, 4);

    // Immediate insn: 4,5,6,7 opcode then 8,9,A,B immediate
    for (int i = 0; i < 4; i++) push_n(4'(8 + i));
    nvld  = 0;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      dcd_imm    = (i == 3);
      dcd_op_vld = (i == 3);
      #1;
      chk("imm_enc", dcd_enc, 4 + i);
      if (dcd_enc_vld) nvld++;
      if (busy) nbusy++;
      cyc();
    end
    dcd_imm    = 1'b0;
    dcd_op_vld = 1'b0;
    #1;
    chk("imm_nvld", nvld, 8);
    chk("imm_nbusy", nbusy, 7);
    chk("imm_end_vld", dcd_enc_vld, 0);
    chk("imm_end_busy", busy, 0);
    chk("imm_end_occ", occ, 0);

    // Flush on nibble 2: nibbles 3,4 are filler, op killed
    for (int i = 0; i < 8; i++) push_n(4'(i + 1));
    #1;
    chk("fl_n1", dcd_enc, 1);
    cyc();
    flush    = 1'b1;
    mem_vld  = 1'b1;
    mem_data = 4'hF;
    #1;
    chk("fl_n2", dcd_enc, 2);
    cyc();
    flush   = 1'b0;
    mem_vld = 1'b0;
    #1;
    chk("fl_n3_enc", dcd_enc, 0);
    chk("fl_n3_vld", dcd_enc_vld, 1);
    chk("fl_occ", occ, 0);
    cyc();
    dcd_op_vld = 1'b1;
    #1;
    chk("fl_n4_enc", dcd_enc, 0);
    chk("fl_n4_vld", dcd_enc_vld, 1);
    chk("fl_n4_exe", exe_op_vld, 0);
    cyc();
    dcd_op_vld = 1'b0;
    #1;
    chk("fl_end_vld", dcd_enc_vld, 0);
    chk("fl_end_busy", busy, 0);
    chk("fl_end_occ", occ, 0);

    // Flush coincident with final nibble; kill must not linger afterwards
    for (int i = 0; i < 8; i++) push_n(4'(i + 1));
    cyc();
    cyc();
    cyc();
    flush      = 1'b1;
    dcd_op_vld = 1'b1;
    #1;
    chk("flf_enc", dcd_enc, 4);
    chk("flf_exe", exe_op_vld, 0);
    cyc();
    flush = 1'b0;
    #1;
    chk("flf_occ", occ, 0);
    chk("flf_vld", dcd_enc_vld, 0);
    chk("flf_nokill", exe_op_vld, 1);
    dcd_op_vld = 1'b0;

    // Flush in IDLE with threshold met: no start, FIFO cleared
    for (int i = 0; i < 8; i++) push_n(4'hA);
    flush = 1'b1;
    #1;
    chk("fli_vld", dcd_enc_vld, 0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fli_occ", occ, 0);
    chk("fli_vld2", dcd_enc_vld, 0);

    // Fill to 16 under stall, then push+pop at full and wrap through 20 nibbles
    exe_stall = 1'b1;
    for (int i = 0; i < 16; i++) push_n(4'(i));
    mem_vld  = 1'b1;
    mem_data = 4'h9;
    #1;
    chk("full_occ", occ, 16);
    chk("full_rdy", mem_rdy, 0);
    chk("stall_vld", dcd_enc_vld, 0);
    exe_stall = 1'b0;
    #1;
    chk("unstall_vld", dcd_enc_vld, 1);
    chk("full_pp_rdy", mem_rdy, 1);
    for (int i = 0; i < 20; i++) begin
      mem_vld = (i < 4);
      if (i < 4) mem_data = wrap_exp[16 + i];
      dcd_imm = (i == 7) || (i == 15);
      #1;
      chk("wrap_enc", dcd_enc, wrap_exp[i]);
      chk("wrap_vld", dcd_enc_vld, 1);
      cyc();
      if (i == 0) chk("full_pp_occ", occ, 16);
    end
    mem_vld = 1'b0;
    dcd_imm = 1'b0;
    #1;
    chk("wrap_end_vld", dcd_enc_vld, 0);
    chk("wrap_end_occ", occ, 0);

    // Asynchronous reset mid-instruction
    for (int i = 0; i < 8; i++) push_n(4'h5);
    cyc();
    #1;
    chk("mid_vld", dcd_enc_vld, 1);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", dcd_enc_vld, 0);
    chk("arst_occ", occ, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", mem_rdy, 1);
    chk("arst_enc", dcd_enc, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
